// File: rtl/inst_fetcher.sv
// Fetch responder: reads the instruction word at pc over a req/ack memory bus.
// Optional one-entry fetch buffer is enabled by defining INST_FETCH_BUF_EN.
module inst_fetcher #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetcher_reset,
    input  logic [31:0]       pc,
    output logic              fetcher_completed,
    output logic [31:0]       instruction,
    output logic              fetch_fault,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state, state_n;
    logic [15:0]       cnt, cnt_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       instr_n;
    logic              completed_n;
    logic              fault_n;
    logic [ADDR_W-1:0] pc_word;
    logic              expired;
    logic              aborting;
    logic              buf_hit;
    logic [31:0]       buf_rdata;
    logic              buf_fill;

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc[1:0], pc[31:ADDR_W+2]};

    assign pc_word  = pc[ADDR_W+1:2];
    assign expired  = (cnt == CNT_LAST);
    // An abort seen in REQ behaves exactly like a DRAIN cycle: the request must still complete.
    assign aborting = (state == DRAIN) || ((state == REQ) && fetcher_reset);

`ifdef INST_FETCH_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [31:0]       buf_data;

    assign buf_hit   = buf_valid && (buf_tag == pc_word);
    assign buf_rdata = buf_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (buf_fill) begin
            buf_valid <= 1'b1;
            buf_tag   <= mem_addr;
            buf_data  <= mem_rdata;
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        mem_req_n   = mem_req;
        mem_addr_n  = mem_addr;
        instr_n     = instruction;
        completed_n = fetcher_completed;
        fault_n     = fetch_fault;
        buf_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (!fetcher_reset) begin
                    if (buf_hit) begin
                        instr_n     = buf_rdata;
                        completed_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        mem_addr_n = pc_word;
                        mem_req_n  = 1'b1;
                        cnt_n      = '0;
                        state_n    = REQ;
                    end
                end
            end
            REQ, DRAIN: begin
                if (aborting) begin
                    if (mem_ack) begin
                        mem_req_n = 1'b0;
                        state_n   = IDLE;
                    end else if (expired) begin
                        fault_n   = 1'b1;
                        mem_req_n = 1'b0;
                        state_n   = IDLE;
                    end else begin
                        cnt_n   = cnt + 16'd1;
                        state_n = DRAIN;
                    end
                end else if (mem_ack) begin
                    instr_n     = mem_rdata;
                    mem_req_n   = 1'b0;
                    completed_n = 1'b1;
                    buf_fill    = 1'b1;
                    state_n     = DONE;
                end else if (expired) begin
                    instr_n     = '0;
                    fault_n     = 1'b1;
                    mem_req_n   = 1'b0;
                    completed_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DONE: begin
                if (fetcher_reset) begin
                    completed_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            mem_req           <= 1'b0;
            mem_addr          <= '0;
            instruction       <= '0;
            fetcher_completed <= 1'b0;
            fetch_fault       <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            mem_req           <= mem_req_n;
            mem_addr          <= mem_addr_n;
            instruction       <= instr_n;
            fetcher_completed <= completed_n;
            fetch_fault       <= fault_n;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed cases plus randomized fetches,
// aborts and timeouts against a transaction-level model of the fetch protocol.
module tb_inst_fetcher;

    localparam int AW       = 14;
    localparam int TO       = 8;
    localparam int NO_ABORT = 1000;
    localparam int NO_ACK   = 1000;
`ifdef INST_FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          fetcher_reset;
    logic [31:0]   pc;
    logic          fetcher_completed;
    logic [31:0]   instruction;
    logic          fetch_fault;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    inst_fetcher #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetcher_reset    (fetcher_reset),
        .pc               (pc),
        .fetcher_completed(fetcher_completed),
        .instruction      (instruction),
        .fetch_fault      (fetch_fault),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: what the fetcher should present between transactions.
    logic [31:0]   inst_exp;
    logic          fault_exp;
    logic          buf_valid;
    logic [AW-1:0] buf_tag;
    logic [31:0]   buf_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_pc(input int idx);
        logic [15:0] hi;
        logic [1:0]  lo;
        hi = 16'($urandom);
        lo = 2'($urandom);
        return {hi, 8'd0, 6'(idx), lo};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            mem_ack = 1'b0;
            check_eq("idle_completed", 32'(fetcher_completed), 32'd0);
            check_eq("idle_req", 32'(mem_req), 32'd0);
            check_eq("idle_instruction", instruction, inst_exp);
            check_eq("idle_fault", 32'(fetch_fault), 32'(fault_exp));
        end
    endtask

    // ack_at / abort_at are bus-cycle indices counted from the first REQ cycle.
    task automatic run_fetch(input logic [31:0] p, input int ack_at, input int abort_at,
                             input bit refall, input logic [31:0] data, input int hold);
        logic [AW-1:0] a;
        bit hit, aborted, finished;
        a        = p[AW+1:2];
        hit      = BUF_EN && buf_valid && (buf_tag == a);
        aborted  = 1'b0;
        finished = 1'b0;
        fetcher_reset = 1'b0;
        pc            = p;
        tick();
        pc = $urandom;
        if (hit) begin
            inst_exp = buf_data;
            check_eq("hit_completed", 32'(fetcher_completed), 32'd1);
            check_eq("hit_no_req", 32'(mem_req), 32'd0);
            check_eq("hit_instruction", instruction, inst_exp);
        end else begin
            check_eq("req_raised", 32'(mem_req), 32'd1);
            check_eq("req_addr", 32'(mem_addr), 32'(a));
            check_eq("req_no_completed", 32'(fetcher_completed), 32'd0);
            for (int j = 0; j < TO && !finished; j++) begin
                if (j >= abort_at)
                    fetcher_reset = (refall && j > abort_at) ? 1'b0 : 1'b1;
                if (j == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = data;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                tick();
                mem_ack = 1'b0;
                if (j >= abort_at) aborted = 1'b1;
                if (j == ack_at) begin
                    finished = 1'b1;
                    if (!aborted) begin
                        inst_exp  = data;
                        buf_valid = 1'b1;
                        buf_tag   = a;
                        buf_data  = data;
                    end
                end else if (j == TO - 1) begin
                    finished  = 1'b1;
                    fault_exp = 1'b1;
                    if (!aborted) inst_exp = '0;
                end else begin
                    check_eq("req_held", 32'(mem_req), 32'd1);
                    check_eq("req_addr_stable", 32'(mem_addr), 32'(a));
                    check_eq("req_no_completed", 32'(fetcher_completed), 32'd0);
                end
            end
            check_eq("end_completed", 32'(fetcher_completed), aborted ? 32'd0 : 32'd1);
            check_eq("end_req", 32'(mem_req), 32'd0);
            check_eq("end_instruction", instruction, inst_exp);
            check_eq("end_fault", 32'(fetch_fault), 32'(fault_exp));
        end
        if (aborted) begin
            if (!refall) fetcher_reset = 1'b1;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
            mem_ack = 1'b0;
            check_eq("done_completed", 32'(fetcher_completed), 32'd1);
            check_eq("done_instruction", instruction, inst_exp);
            check_eq("done_no_req", 32'(mem_req), 32'd0);
        end
        fetcher_reset = 1'b1;
        tick();
        check_eq("release_completed", 32'(fetcher_completed), 32'd0);
        check_eq("release_instruction", instruction, inst_exp);
        check_eq("release_req", 32'(mem_req), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_completed"}, 32'(fetcher_completed), 32'd0);
        check_eq({tag, "_instruction"}, instruction, 32'd0);
        check_eq({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        check_eq({tag, "_req"}, 32'(mem_req), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    endtask

    task automatic model_reset();
        inst_exp  = '0;
        fault_exp = 1'b0;
        buf_valid = 1'b0;
        buf_tag   = '0;
        buf_data  = '0;
    endtask

    initial begin
        reset         = 1'b1;
        fetcher_reset = 1'b1;
        pc            = '0;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        model_reset();
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        idle_cycles(2);

        run_fetch(32'h0000_0040, 3, NO_ABORT, 1'b0, 32'hDEAD_BEEF, 3);
        check_eq("pc40_addr", 32'(mem_addr), 32'h10);
        idle_cycles(2);
        run_fetch(32'h0000_0100, 0, NO_ABORT, 1'b0, $urandom, 0);
        idle_cycles(5);
        run_fetch(32'h0000_0200, 5, 1, 1'b0, 32'h1234_5678, 0);
        idle_cycles(2);
        run_fetch(32'h0000_0300, NO_ACK, NO_ABORT, 1'b0, $urandom, 1);
        idle_cycles(1);
        run_fetch(32'h0000_0044, 1, NO_ABORT, 1'b0, $urandom, 1);
        run_fetch(32'h0000_0048, TO - 1, NO_ABORT, 1'b0, $urandom, 0);
        run_fetch(32'h0000_0080, 2, NO_ABORT, 1'b0, 32'hCAFE_0080, 1);
        run_fetch(32'h0000_0080, 2, NO_ABORT, 1'b0, 32'h5555_AAAA, 1);
        run_fetch(32'h0000_0084, 1, NO_ABORT, 1'b0, 32'hCAFE_0084, 1);
        idle_cycles(1);

        for (int t = 0; t < 60; t++) begin
            int kind, ack_at, abort_at;
            logic [31:0] p;
            p    = make_pc($urandom_range(30, 37));
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                abort_at = $urandom_range(0, TO - 3);
                ack_at   = $urandom_range(abort_at + 1, TO + 1);
                run_fetch(p, ack_at, abort_at, 1'($urandom_range(0, 1)), $urandom, 0);
            end else begin
                ack_at = $urandom_range(0, TO + 1);
                run_fetch(p, ack_at, NO_ABORT, 1'b0, $urandom, $urandom_range(0, 2));
            end
            if (fetcher_reset) idle_cycles($urandom_range(0, 2));
        end

        fetcher_reset = 1'b1;
        idle_cycles(1);
        fetcher_reset = 1'b0;
        pc            = 32'h0000_0500;
        tick();
        tick();
        check_eq("midreq_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_state("midreq_reset");
        reset         = 1'b0;
        fetcher_reset = 1'b1;
        model_reset();
        idle_cycles(2);
        run_fetch(32'h0000_0080, 0, NO_ABORT, 1'b0, 32'h0BAD_F00D, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
